// File: rtl/rom_fetch_ctrl_if.sv
// rtl/rom_fetch_ctrl_if.sv - fetch/ROM/decode signal bundle for rom_fetch_ctrl
interface rom_fetch_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 14
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] ir;
    logic              ir_valid;
    logic [ADDR_W-1:0] pc;
    logic              stall;
    logic              load_pc;
    logic [ADDR_W-1:0] load_addr;
    logic              push;
    logic              pop;
    logic              skip;
    logic              stk_ovf;
    logic              stk_unf;

    modport master (
        output rom_addr, ir, ir_valid, pc, stk_ovf, stk_unf,
        input  rom_data, stall, load_pc, load_addr, push, pop, skip
    );

    modport slave (
        input  rom_addr, ir, ir_valid, pc, stk_ovf, stk_unf,
        output rom_data, stall, load_pc, load_addr, push, pop, skip
    );
endinterface

// File: rtl/rom_fetch_ctrl.sv
// rtl/rom_fetch_ctrl.sv - program counter, instruction register and return stack
module rom_fetch_ctrl #(
    parameter int                ADDR_W       = 11,
    parameter int                DATA_W       = 14,
    parameter int                STACK_DEPTH  = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [DATA_W-1:0] NOP_WORD     = '0
) (
    input  logic              clk,
    input  logic              rst,
    rom_fetch_ctrl_if.master  bus
);
    localparam int SP_W  = $clog2(STACK_DEPTH);
    localparam int CNT_W = SP_W + 1;
    localparam logic [SP_W-1:0]  SP_ONE   = SP_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stk_ovf_q, stk_ovf_d;
    logic              stk_unf_q, stk_unf_d;

    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic              stack_we;

    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        sp_d       = sp_q;
        cnt_d      = cnt_q;
        stk_ovf_d  = stk_ovf_q;
        stk_unf_d  = stk_unf_q;
        stack_we   = 1'b0;

        if (bus.stall) begin
            // decode holds its request lines until the stall drops
        end else if (bus.load_pc) begin
            pc_d       = bus.load_addr;
            ir_d       = NOP_WORD;
            ir_valid_d = 1'b0;
            if (bus.push) begin
                stack_we = 1'b1;
                sp_d     = sp_q + SP_ONE;
                if (cnt_q == CNT_FULL) begin
                    stk_ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end else if (bus.pop) begin
            // an empty-stack pop still follows the wrapped pointer
            pc_d       = stack_q[sp_q - SP_ONE];
            sp_d       = sp_q - SP_ONE;
            ir_d       = NOP_WORD;
            ir_valid_d = 1'b0;
            if (cnt_q == '0) begin
                stk_unf_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else if (bus.skip) begin
            pc_d       = pc_q + ADDR_W'(1);
            ir_d       = NOP_WORD;
            ir_valid_d = 1'b0;
        end else begin
            pc_d       = pc_q + ADDR_W'(1);
            ir_d       = bus.rom_data;
            ir_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            ir_q       <= NOP_WORD;
            ir_valid_q <= 1'b0;
            sp_q       <= '0;
            cnt_q      <= '0;
            stk_ovf_q  <= 1'b0;
            stk_unf_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            sp_q       <= sp_d;
            cnt_q      <= cnt_d;
            stk_ovf_q  <= stk_ovf_d;
            stk_unf_q  <= stk_unf_d;
        end
    end

    // Return-address storage carries no reset; only sp/cnt define its contents.
    always_ff @(posedge clk) begin
        if (stack_we) begin
            stack_q[sp_q] <= pc_q;
        end
    end

    assign bus.rom_addr = pc_q;
    assign bus.pc       = pc_q;
    assign bus.ir       = ir_q;
    assign bus.ir_valid = ir_valid_q;
    assign bus.stk_ovf  = stk_ovf_q;
    assign bus.stk_unf  = stk_unf_q;
endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// tb/tb_rom_fetch_ctrl.sv - scoreboard bench for rom_fetch_ctrl with directed vectors
module tb_rom_fetch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;

    rom_fetch_ctrl_if #(.ADDR_W(11), .DATA_W(14)) bus ();

    rom_fetch_ctrl #(
        .ADDR_W(11), .DATA_W(14), .STACK_DEPTH(8),
        .RESET_VECTOR(11'h000), .NOP_WORD(14'h0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.rom_data = {3'b000, bus.rom_addr} + 14'h100;

    typedef struct {
        string       name;
        logic [10:0] pc;
        logic [13:0] ir;
        logic        v;
        logic        ovf;
        logic        unf;
        bit          chk_pc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    logic cur_ovf  = 1'b0;
    logic cur_unf  = 1'b0;

    always begin
        @(posedge clk or posedge rst);
        #2;
        while (q.size() > 0) begin
            exp_t e;
            logic bad;
            e = q.pop_front();
            checks++;
            bad = (bus.ir !== e.ir) || (bus.ir_valid !== e.v) ||
                  (bus.stk_ovf !== e.ovf) || (bus.stk_unf !== e.unf) ||
                  (bus.rom_addr !== bus.pc);
            if (e.chk_pc && (bus.pc !== e.pc)) bad = 1'b1;
            if (bad) begin
                failures++;
                $display("FAIL %s: got pc=%h rom_addr=%h ir=%h v=%b ovf=%b unf=%b, want pc=%h ir=%h v=%b ovf=%b unf=%b",
                         e.name, bus.pc, bus.rom_addr, bus.ir, bus.ir_valid, bus.stk_ovf, bus.stk_unf,
                         e.pc, e.ir, e.v, e.ovf, e.unf);
            end
        end
    end

    task automatic step(input string nm, input logic st, input logic ld, input logic [10:0] la,
                        input logic ps, input logic pp, input logic sk,
                        input logic [10:0] epc, input logic [13:0] eir, input logic ev,
                        input bit cpc = 1'b1);
        exp_t e;
        bus.stall = st; bus.load_pc = ld; bus.load_addr = la;
        bus.push = ps; bus.pop = pp; bus.skip = sk;
        @(posedge clk);
        e.name = nm; e.pc = epc; e.ir = eir; e.v = ev;
        e.ovf = cur_ovf; e.unf = cur_unf; e.chk_pc = cpc;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input string nm, input logic [10:0] epc, input logic [13:0] eir);
        step(nm, 1'b0, 1'b0, 11'h0, 1'b0, 1'b0, 1'b0, epc, eir, 1'b1);
    endtask

    task automatic do_reset(input string nm);
        exp_t e;
        cur_ovf = 1'b0; cur_unf = 1'b0;
        e.name = nm; e.pc = 11'h000; e.ir = 14'h0000; e.v = 1'b0;
        e.ovf = 1'b0; e.unf = 1'b0; e.chk_pc = 1'b1;
        q.push_back(e);
        rst = 1'b1;
        #3;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.stall = 0; bus.load_pc = 0; bus.load_addr = '0;
        bus.push = 0; bus.pop = 0; bus.skip = 0;
        #1;
        do_reset("reset_state");

        run("fetch1", 11'h001, 14'h100);
        run("fetch2", 11'h002, 14'h101);
        run("fetch3", 11'h003, 14'h102);
        run("fetch4", 11'h004, 14'h103);
        run("fetch5", 11'h005, 14'h104);

        step("goto_bubble", 0, 1, 11'h020, 0, 0, 0, 11'h020, 14'h000, 0);
        run("goto_fetch", 11'h021, 14'h120);

        step("goto_012", 0, 1, 11'h012, 0, 0, 0, 11'h012, 14'h000, 0);
        step("call_040", 0, 1, 11'h040, 1, 0, 0, 11'h040, 14'h000, 0);
        run("callee1", 11'h041, 14'h140);
        run("callee2", 11'h042, 14'h141);
        step("return_012", 0, 0, 11'h0, 0, 1, 0, 11'h012, 14'h000, 0);
        run("after_ret", 11'h013, 14'h112);

        for (int i = 1; i <= 9; i++) begin
            logic [10:0] t;
            t = 11'h100 + 11'(16 * (i - 1));
            if (i == 9) cur_ovf = 1'b1;
            step($sformatf("nest_call%0d", i), 0, 1, t, 1, 0, 0, t, 14'h000, 0);
        end
        for (int k = 0; k < 8; k++) begin
            logic [10:0] r;
            r = 11'h170 - 11'(16 * k);
            step($sformatf("nest_ret%0d", k), 0, 0, 11'h0, 0, 1, 0, r, 14'h000, 0);
        end

        cur_unf = 1'b1;
        step("unf_pop_a", 0, 0, 11'h0, 0, 1, 0, 11'h170, 14'h000, 0);
        step("unf_pop_b", 0, 0, 11'h0, 0, 1, 0, 11'h160, 14'h000, 0);
        run("after_unf", 11'h161, 14'h260);

        step("stall1", 1, 1, 11'h7ff, 0, 0, 0, 11'h161, 14'h260, 1);
        step("stall2", 1, 1, 11'h7ff, 0, 0, 0, 11'h161, 14'h260, 1);
        step("stall3", 1, 1, 11'h7ff, 0, 0, 0, 11'h161, 14'h260, 1);
        step("unstall_goto", 0, 1, 11'h7ff, 0, 0, 0, 11'h7ff, 14'h000, 0);
        step("skip_wrap", 0, 0, 11'h0, 0, 0, 1, 11'h000, 14'h000, 0);
        run("post_wrap", 11'h001, 14'h100);
        step("push_alone", 0, 0, 11'h0, 1, 0, 0, 11'h002, 14'h101, 1);

        step("call_a", 0, 1, 11'h100, 1, 0, 0, 11'h100, 14'h000, 0);
        step("call_b", 0, 1, 11'h120, 1, 0, 0, 11'h120, 14'h000, 0);
        step("call_c", 0, 1, 11'h153, 1, 0, 0, 11'h153, 14'h000, 0);
        run("run_154", 11'h154, 14'h253);
        run("run_155", 11'h155, 14'h254);
        do_reset("async_reset");

        run("post_rst_fetch", 11'h001, 14'h100);
        cur_unf = 1'b1;
        step("post_rst_pop", 0, 0, 11'h0, 0, 1, 0, 11'h000, 14'h000, 0, 1'b0);

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rom_fetch_ctrl.md
Name: rom_fetch_ctrl

Overview:
Instruction-fetch sequencer for the 14-bit program ROM of the pipelined MCU.
- Owns the program counter, drives the ROM address and latches the returned word into the instruction register for decode.
- Services jump/call/return redirects, skip flushes and pipeline stalls.
- Maintains the hardware return-address stack.

Parameters:
ADDR_W, 11, program address width (ROM depth 2**ADDR_W words)
DATA_W, 14, instruction word width
STACK_DEPTH, 8, return-stack entries (power of two)
RESET_VECTOR, 0, PC value after reset
NOP_WORD, 14'h0000, word injected into IR on flush

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
rom_addr  out  ADDR_W  address to program ROM; combinational copy of pc
rom_data  in  DATA_W  ROM output for rom_addr; combinational, same cycle
ir  out  DATA_W  fetched instruction to decode
ir_valid  out  1  ir holds a real fetched word (0 = bubble/NOP)
pc  out  ADDR_W  current fetch address
stall  in  1  freeze fetch state this cycle
load_pc  in  1  redirect (GOTO/CALL) to load_addr
load_addr  in  ADDR_W  redirect target
push  in  1  with load_pc: push return address (CALL)
pop  in  1  redirect to top of stack (RETURN/RETLW)
skip  in  1  discard the word being fetched this cycle
stk_ovf  out  1  sticky: push with stack full
stk_unf  out  1  sticky: pop with stack empty

Behaviour:
- Reset (async, any time including mid-redirect):
  - pc=RESET_VECTOR, ir=NOP_WORD, ir_valid=0.
  - Stack pointer sp=0, occupancy cnt=0, stk_ovf=0, stk_unf=0.
  - Stack contents undefined.
- rom_addr = pc at all times; no registered delay. Fetch latency 1 cycle: the word at address A appears on ir the edge after pc==A.
- Per rising edge, exactly one case applies, in priority order:
  1. stall=1: pc, ir, ir_valid, stack and flags all hold. load_pc/push/pop/skip are ignored; decode keeps them asserted until stall drops.
  2. load_pc=1:
     - pc<=load_addr; ir<=NOP_WORD; ir_valid<=0 (one-bubble flush).
     - If push=1: stack[sp]<=pc (the address after the CALL), sp<=sp+1 mod STACK_DEPTH.
     - If cnt==STACK_DEPTH on push: oldest entry is overwritten (circular), cnt stays, stk_ovf<=1. Otherwise cnt<=cnt+1.
     - pop is ignored when load_pc=1.
  3. pop=1:
     - pc<=stack[sp-1]; sp<=sp-1 mod STACK_DEPTH; ir<=NOP_WORD; ir_valid<=0.
     - If cnt==0: stk_unf<=1, the wrapped entry is still used, cnt stays 0. Otherwise cnt<=cnt-1.
  4. skip=1: pc<=pc+1; ir<=NOP_WORD; ir_valid<=0.
  5. Otherwise: pc<=pc+1; ir<=rom_data; ir_valid<=1.
- push without load_pc is ignored.
- pc increment wraps modulo 2**ADDR_W (7FF -> 000), with no flag.
- Stack width is ADDR_W. sp and cnt are internal; cnt ranges 0..STACK_DEPTH.
- stk_ovf and stk_unf clear only on reset.
- Back-to-back redirects are legal: each one produces its own bubble.

Test Plan:
- Reset then run, ROM model rom[n]=n+14'h100 -> ir_valid=0 after reset. First edge: ir=14'h100, pc=1. Edge 4: ir=14'h103, pc=4.
- load_pc at pc=5, load_addr=11'h020 -> next edge ir=0000, ir_valid=0, pc=020. Following edge ir=rom[020], ir_valid=1.
- CALL at pc=0x012 (load_pc+push, target 0x040), then pop 3 cycles later -> pc returns to 0x012, one bubble per redirect, stk_ovf=stk_unf=0.
- 9 nested CALLs with STACK_DEPTH=8, then 8 pops -> stk_ovf=1 after the 9th push. Pops return the 9th..2nd return addresses; the first is lost.
- pop with empty stack -> stk_unf=1, pc=stack[7] contents, cnt stays 0.
- stall held 3 cycles during load_pc -> pc/ir frozen. Redirect executes on the first unstalled edge. Skip at pc=7FF -> ir=NOP, pc wraps to 000.
- Assert rst mid-stream with pc=0x155 and cnt=3 -> outputs clear immediately (no clock needed). First post-reset fetch is from RESET_VECTOR.
